// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Each digit is scanned in turn, and a short blanked guard interval between digits prevents ghosting.
module seg7_scan #(
    parameter int REFRESH_BITS = 16,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame
);

    localparam int GUARD_I = 1 << (REFRESH_BITS - 4);
    localparam logic [REFRESH_BITS-1:0] GUARD = GUARD_I[REFRESH_BITS-1:0];

    logic [15:0]             disp_val_q, disp_val_d;
    logic [3:0]              disp_dp_q, disp_dp_d;
    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_q, frame_d;

    logic                    cnt_wrap;
    logic                    in_guard;
    logic [3:0]              upper_zero;
    logic                    digit_blank;
    logic [3:0]              cur_nibble;

    // Active-high segment pattern, bit 0 = a through bit 6 = g.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign cnt_wrap   = &cnt_q;
    assign in_guard   = (cnt_q < GUARD);
    assign cur_nibble = disp_val_q[{idx_q, 2'b00} +: 4];

    // upper_zero[k] is set when every nibble from k up to 3 is zero.
    assign upper_zero[3] = (disp_val_q[15:12] == 4'h0);
    assign upper_zero[2] = upper_zero[3] && (disp_val_q[11:8] == 4'h0);
    assign upper_zero[1] = upper_zero[2] && (disp_val_q[7:4] == 4'h0);
    assign upper_zero[0] = 1'b0;

    assign digit_blank = LZ_BLANK && upper_zero[idx_q];

    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (load) begin
            disp_val_d = value;
            disp_dp_d  = dp_in;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
        an_d    = 4'hF;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        frame_d = cnt_wrap && (idx_q == 2'd3);
        if (!in_guard && !digit_blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = ~decode(cur_nibble);
            dp_d  = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_val_q <= 16'h0000;
            disp_dp_q  <= 4'h0;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign an_n  = an_q;
    assign seg_n = seg_q;
    assign dp_n  = dp_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: two instances (blanking off/on) compared every cycle
// against a time-index model of the scan, plus directed checkpoints.
module tb_seg7_scan;

    localparam int RB    = 6;
    localparam int SLOT  = 64;
    localparam int GUARD = 4;
    localparam int FRAME = 4 * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } out_t;

    localparam out_t BLANK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fr: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;

    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dpo0, dpo1, fr0, fr1;

    always #5 clk = ~clk;

    seg7_scan #(.REFRESH_BITS(RB), .LZ_BLANK(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
        .an_n(an0), .seg_n(seg0), .dp_n(dpo0), .frame(fr0)
    );

    seg7_scan #(.REFRESH_BITS(RB), .LZ_BLANK(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
        .an_n(an1), .seg_n(seg1), .dp_n(dpo1), .frame(fr1)
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: the display contents and the number of running edges since reset.
    logic [15:0] m_val = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    int          m_t = 0;
    int          cyc = 0;
    int          last_frame = -1;
    int          frame_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [6:0] nseg(input logic [6:0] x);
        return ~x;
    endfunction

    // The time since reset alone determines the slot and the position within it.
    function automatic out_t model_out(input bit lz, input logic [15:0] v,
                                       input logic [3:0] dpv, input int t);
        int   pos;
        int   dig;
        bit   blank;
        out_t o;
        pos   = t % SLOT;
        dig   = (t / SLOT) % 4;
        blank = lz && (dig > 0) && ((v >> (4 * dig)) == 16'h0000);
        o     = BLANK;
        if (pos >= GUARD && !blank) begin
            o.an  = ~(4'b0001 << dig);
            o.seg = ~seg_tab[(v >> (4 * dig)) & 16'hF];
            o.dp  = ~dpv[dig];
        end
        o.fr = (dig == 3) && (pos == SLOT - 1);
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        out_t e0, e1;
        if (!rst_n) begin
            e0 = BLANK;
            e1 = BLANK;
        end else begin
            e0 = model_out(1'b0, m_val, m_dp, m_t);
            e1 = model_out(1'b1, m_val, m_dp, m_t);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_val      = 16'h0000;
            m_dp       = 4'h0;
            m_t        = 0;
            last_frame = -1;
        end else begin
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
            end
            m_t++;
        end
        cyc++;
        #1;
        chk("an0", an0, e0.an);
        chk("seg0", seg0, e0.seg);
        chk("dp0", dpo0, e0.dp);
        chk("frame0", fr0, e0.fr);
        chk("an1", an1, e1.an);
        chk("seg1", seg1, e1.seg);
        chk("dp1", dpo1, e1.dp);
        chk("frame1", fr1, e1.fr);
        if (fr1) begin
            if (last_frame >= 0) chk("frame_gap", cyc - last_frame, FRAME);
            last_frame = cyc;
            frame_cnt++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the most recent edge was computed from scan position 'target'.
    task automatic run_until(input int target);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (m_t >= 1 && ((m_t - 1) % FRAME) == target) return;
        end
        chk("run_until_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        // Reset held with load active.
        rst_n = 1'b0;
        load  = 1'b1;
        value = 16'h1234;
        ticks(5);
        chk("rst_an", an0, 4'hF);
        chk("rst_seg", seg0, 7'h7F);
        load  = 1'b0;
        rst_n = 1'b1;
        ticks(GUARD);
        chk("post_rst_guard_an", an0, 4'hF);
        tick();
        chk("post_rst_first_an", an0, 4'hE);
        chk("post_rst_first_seg", seg0, nseg(7'h3F));

        // Hex scan without blanking.
        do_load(16'hA5C3, 4'b0100);
        run_until(0 * SLOT + 10);
        chk("hex_d0_an", an0, 4'hE);
        chk("hex_d0_seg", seg0, nseg(7'h4F));
        run_until(1 * SLOT + 2);
        chk("hex_d1_guard", an0, 4'hF);
        run_until(1 * SLOT + 10);
        chk("hex_d1_seg", seg0, nseg(7'h39));
        run_until(2 * SLOT + 10);
        chk("hex_d2_an", an0, 4'hB);
        chk("hex_d2_seg", seg0, nseg(7'h6D));
        chk("hex_d2_dp", dpo0, 1'b0);
        run_until(3 * SLOT + 10);
        chk("hex_d3_an", an0, 4'h7);
        chk("hex_d3_seg", seg0, nseg(7'h77));

        // Leading-zero blanking.
        do_load(16'h0042, 4'h0);
        run_until(3 * SLOT + 30);
        chk("lz42_d3_an", an1, 4'hF);
        run_until(2 * SLOT + 30);
        chk("lz42_d2_an", an1, 4'hF);
        chk("nolz42_d2_an", an0, 4'hB);
        run_until(1 * SLOT + 30);
        chk("lz42_d1_seg", seg1, nseg(7'h66));
        do_load(16'h0000, 4'h0);
        run_until(1 * SLOT + 30);
        chk("lz0_d1_an", an1, 4'hF);
        run_until(0 * SLOT + 30);
        chk("lz0_d0_seg", seg1, nseg(7'h3F));
        do_load(16'h0400, 4'h0);
        run_until(1 * SLOT + 30);
        chk("lz400_d1_an", an1, 4'hD);
        chk("lz400_d1_seg", seg1, nseg(7'h3F));

        // Frame period across three frames.
        run_until(FRAME - 1);
        chk("frame_pulse", fr0, 1'b1);
        frame_cnt = 0;
        ticks(3 * FRAME);
        chk("frame_count", frame_cnt, 3);

        // Reset during a lit digit 2.
        do_load(16'h9876, 4'h0);
        run_until(2 * SLOT + 20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_an", an0, 4'hF);
        chk("midrst_seg", seg0, 7'h7F);
        ticks(GUARD);
        chk("midrst_guard_an", an0, 4'hF);
        tick();
        chk("midrst_d0_an", an0, 4'hE);
        chk("midrst_cleared_seg", seg0, nseg(7'h3F));

        // Load latency on a lit digit.
        do_load(16'h0001, 4'h0);
        run_until(0 * SLOT + 10);
        chk("lat_before", seg0, nseg(7'h06));
        do_load(16'h0007, 4'h0);
        chk("lat_load_edge", seg0, nseg(7'h06));
        tick();
        chk("lat_after_seg", seg0, nseg(7'h07));
        chk("lat_after_an", an0, 4'hE);

        // Randomized loads, gaps and occasional resets.
        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            do_load(16'($urandom) & ((16'h1 << (4 * (sel + 1))) - 16'h1), 4'($urandom));
            ticks($urandom_range(1, 120));
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                ticks($urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end
        ticks(FRAME);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
